// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and default sizes for the BCD formatter
package div_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam int WIDTH_DEF  = 16;
    localparam int DIGITS_DEF = 5;
    localparam int BCD_W      = 4 * DIGITS_DEF;
endpackage

// File: rtl/bcd_dabble_step.sv
// bcd_dabble_step: one combinational double-dabble iteration (add-3 then shift left)
module bcd_dabble_step import div_pkg::*; #(
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic [4*DIGITS-1:0] bcd_in,
    input  logic                bit_in,
    output logic [4*DIGITS-1:0] bcd_out,
    output logic                bit_out
);
    logic [4*DIGITS-1:0] adj;
    // every digit of five or more is pre-corrected so the shift carries into the next digit
    always_comb begin
        for (int i = 0; i < DIGITS; i++)
            adj[4*i+:4] = (bcd_in[4*i+:4] >= 4'd5) ? bcd_in[4*i+:4] + 4'd3 : bcd_in[4*i+:4];
    end
    assign bcd_out = {adj[4*DIGITS-2:0], bit_in};
    assign bit_out = adj[4*DIGITS-1];
endmodule

// File: rtl/div_bcd_formatter.sv
// div_bcd_formatter: converts a quotient/remainder pair to packed BCD between two handshakes
module div_bcd_formatter import div_pkg::*; #(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int DIGITS = DIGITS_DEF,
    parameter int CNT_W  = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    quot,
    input  logic [WIDTH-1:0]    rem,
    input  logic                div_zero,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] quot_bcd,
    output logic [4*DIGITS-1:0] rem_bcd,
    output logic                out_err
);
    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt;
    logic [WIDTH-1:0]    qbin, rbin;
    logic [4*DIGITS-1:0] qbcd, rbcd, qbcd_n, rbcd_n;
    logic                q_spill, r_spill, err;
    logic                accept, last;

    assign accept    = in_valid && state == IDLE;
    assign last      = cnt == CNT_W'(WIDTH - 1);
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign quot_bcd  = qbcd;
    assign rem_bcd   = rbcd;
    assign out_err   = err;

    bcd_dabble_step #(.DIGITS(DIGITS)) u_q (
        .bcd_in(qbcd), .bit_in(qbin[WIDTH-1]), .bcd_out(qbcd_n), .bit_out(q_spill)
    );
    bcd_dabble_step #(.DIGITS(DIGITS)) u_r (
        .bcd_in(rbcd), .bit_in(rbin[WIDTH-1]), .bcd_out(rbcd_n), .bit_out(r_spill)
    );

    // next-state: divide-by-zero skips the conversion entirely
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = accept ? (div_zero ? DONE : SHIFT) : IDLE;
            SHIFT:   state_n = last ? DONE : SHIFT;
            DONE:    state_n = out_ready ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end

    // state register; reset abandons any conversion in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // datapath: load on accept, iterate in SHIFT; {bcd,bin} rotate so the spill bit is never lost
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            qbin <= '0;
            rbin <= '0;
            qbcd <= '0;
            rbcd <= '0;
            err  <= 1'b0;
        end else if (accept) begin
            cnt  <= '0;
            qbin <= div_zero ? '0 : quot;
            rbin <= div_zero ? '0 : rem;
            qbcd <= '0;
            rbcd <= '0;
            err  <= div_zero;
        end else if (state == SHIFT) begin
            cnt  <= cnt + CNT_W'(1);
            qbin <= {qbin[WIDTH-2:0], q_spill};
            rbin <= {rbin[WIDTH-2:0], r_spill};
            qbcd <= qbcd_n;
            rbcd <= rbcd_n;
        end
    end
endmodule

// File: tb/tb_div_bcd_formatter.sv
// tb_div_bcd_formatter: randomized self-checking bench against an arithmetic decimal model
module tb_div_bcd_formatter;
    localparam int WIDTH = 16;
    localparam int DIGITS = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [WIDTH-1:0]  quot = '0;
    logic [WIDTH-1:0]  rem = '0;
    logic              div_zero = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [4*DIGITS-1:0] quot_bcd, rem_bcd;
    logic              out_err;

    int errors = 0;
    int checks = 0;
    logic [40:0] mon[$];
    time acc_t[3];

    div_bcd_formatter dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .quot(quot), .rem(rem), .div_zero(div_zero), .out_valid(out_valid),
        .out_ready(out_ready), .quot_bcd(quot_bcd), .rem_bcd(rem_bcd), .out_err(out_err)
    );

    always #5 clk = ~clk;

    // record every completed output transfer
    always @(posedge clk) if (out_valid && out_ready) mon.push_back({out_err, quot_bcd, rem_bcd});

    function automatic logic [19:0] to_bcd(input int unsigned v);
        logic [19:0] r;
        int unsigned x;
        x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i+:4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run_op(input logic [15:0] q, input logic [15:0] r, input logic dz, input int hold);
        logic [19:0] eq, er;
        logic [40:0] snap;
        logic busy_bad, stab_bad;
        int k;
        eq = dz ? 20'h0 : to_bcd(32'(q));
        er = dz ? 20'h0 : to_bcd(32'(r));
        @(negedge clk);
        quot = q; rem = r; div_zero = dz; in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 40) begin @(negedge clk); k++; end
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        quot = 16'($urandom); rem = 16'($urandom); div_zero = 1'($urandom);
        busy_bad = 1'b0;
        k = 0;
        do begin
            @(posedge clk); @(negedge clk); k++;
            if (!out_valid && in_ready) busy_bad = 1'b1;
        end while (!out_valid && k < 40);
        check("latency", 32'(k), dz ? 32'd1 : 32'(WIDTH));
        check("out_valid", 32'(out_valid), 32'd1);
        check("in_ready_busy", 32'(busy_bad || in_ready), 32'd0);
        check("out_err", 32'(out_err), 32'(dz));
        check("quot_bcd", 32'(quot_bcd), 32'(eq));
        check("rem_bcd", 32'(rem_bcd), 32'(er));
        snap = {out_err, quot_bcd, rem_bcd};
        stab_bad = 1'b0;
        repeat (hold) begin
            @(negedge clk);
            if ({out_err, quot_bcd, rem_bcd} !== snap || !out_valid || in_ready) stab_bad = 1'b1;
        end
        check("hold_stable", 32'(stab_bad), 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        check("after_xfer_valid", 32'(out_valid), 32'd0);
        check("after_xfer_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        logic bad;
        logic [15:0] sq[3];
        logic [15:0] sr[3];
        int k;
        #2;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_err", 32'(out_err), 32'd0);
        check("rst_quot", 32'(quot_bcd), 32'd0);
        check("rst_rem", 32'(rem_bcd), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        run_op(16'd2, 16'd2, 1'b0, 0);
        run_op(16'd65535, 16'd0, 1'b0, 1);
        run_op(16'd1000, 16'd999, 1'b0, 0);
        run_op(16'd4321, 16'd59999, 1'b0, 10);
        run_op(16'hDEAD, 16'hBEEF, 1'b1, 2);
        run_op(16'd2, 16'd1, 1'b0, 0);

        // reset asserted between edges in the middle of a conversion
        @(negedge clk);
        quot = 16'd54321; rem = 16'd777; div_zero = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_quot", 32'(quot_bcd), 32'd0);
        check("midrst_rem", 32'(rem_bcd), 32'd0);
        check("midrst_err", 32'(out_err), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (20) begin @(negedge clk); if (out_valid || !in_ready) bad = 1'b1; end
        check("no_stale_result", 32'(bad), 32'd0);
        run_op(16'd12345, 16'd0, 1'b0, 0);

        for (int i = 0; i < 20; i++)
            run_op(16'($urandom), 16'($urandom), ($urandom_range(7) == 0), int'($urandom_range(3)));

        // streaming with out_ready held high
        mon.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sq[i] = 16'($urandom); sr[i] = 16'($urandom);
            @(negedge clk);
            quot = sq[i]; rem = sr[i]; div_zero = 1'b0; in_valid = 1'b1;
            k = 0;
            while (!in_ready && k < 60) begin @(negedge clk); k++; end
            check("stream_ready", 32'(in_ready), 32'd1);
            @(posedge clk);
            acc_t[i] = $time;
            #1 in_valid = 1'b0;
        end
        repeat (25) @(negedge clk);
        out_ready = 1'b0;
        check("stream_gap01", 32'((acc_t[1] - acc_t[0]) / 10), 32'(WIDTH + 2));
        check("stream_gap12", 32'((acc_t[2] - acc_t[1]) / 10), 32'(WIDTH + 2));
        check("stream_count", 32'(mon.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < mon.size()) begin
                check("stream_err", 32'(mon[i][40]), 32'd0);
                check("stream_quot", 32'(mon[i][39:20]), 32'(to_bcd(32'(sq[i]))));
                check("stream_rem", 32'(mon[i][19:0]), 32'(to_bcd(32'(sr[i]))));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
